shift_add_mul_ctrl: RTL and testbench

//  Sequential 8x8 unsigned multiplier; one start/busy/done handshake per product.

---
 rtl/shift_add_mul_ctrl_pkg.sv | 21 ++
 rtl/adder_8bit.sv | 11 +
 rtl/shift_add_mul_ctrl.sv | 91 +++++++++
 tb/tb_shift_add_mul_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/shift_add_mul_ctrl_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
package shift_add_mul_ctrl_pkg;

  // Operand width is fixed by adder_8bit.
  localparam int unsigned WIDTH  = 8;
  // Iteration counter width; must be able to hold WIDTH.
  localparam int unsigned CNT_W  = 4;
  // Product width.
  localparam int unsigned PROD_W = 2 * WIDTH;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Value of the iteration counter on the final RUN cycle.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

endpackage

// File: rtl/adder_8bit.sv
// Existing shared 8-bit combinational adder; no carry-out.
module adder_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] sum
);

  // Modulo-256 sum.
  assign sum = a + b;

endmodule

// File: rtl/shift_add_mul_ctrl.sv
// Sequential 8x8 unsigned multiplier: one shift-and-add step per RUN cycle
// through a single shared adder_8bit, with a start/busy/done handshake.
module shift_add_mul_ctrl
  import shift_add_mul_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic              busy,
  output logic              done,
  output logic [PROD_W-1:0] product
);

  state_t             state;
  logic [WIDTH-1:0]   m_reg;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   q_reg;
  logic [CNT_W-1:0]   cnt;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               carry;
  logic [WIDTH-1:0]   a_next;
  logic [WIDTH-1:0]   q_next;

  // Add the multiplicand only when the current multiplier LSB is set.
  assign addend = q_reg[0] ? m_reg : '0;

  adder_8bit u_adder (
    .a   (a_reg),
    .b   (addend),
    .sum (sum)
  );

  // The adder drops its carry; an unsigned wrap shows up as sum < A.
  assign carry  = (sum < a_reg);
  // {A,Q} <= {C,sum,Q} >> 1
  assign a_next = {carry, sum[WIDTH-1:1]};
  assign q_next = {sum[0], q_reg[WIDTH-1:1]};

  // Controller FSM with iteration counter, datapath registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      m_reg   <= '0;
      a_reg   <= '0;
      q_reg   <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            m_reg <= a;
            q_reg <= b;
            a_reg <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_reg <= a_next;
          q_reg <= q_next;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            product <= {a_next, q_next};
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
// Self-checking bench for shift_add_mul_ctrl against an arithmetic reference.
module tb_shift_add_mul_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int checks;
  int failures;

  shift_add_mul_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain unsigned multiply.
  function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
    return 16'(x) * 16'(y);
  endfunction

  // Issue one operation (caller is #1 after an edge, DUT idle) and observe
  // 13 samples, the first taken just after the accepting edge.
  // With interfere set, start stays high with a=b=1 through the DONE cycle.
  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input bit interfere,
                        output int nbusy, output int done_at, output int ndone,
                        output logic [15:0] prod, output bit overlap,
                        output logic [15:0] prod_hold);
    a = ia; b = ib; start = 1'b1;
    nbusy = 0; done_at = -1; ndone = 0; prod = '0; overlap = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 13; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        if (done_at < 0) begin done_at = i; prod = product; end
      end
      if (busy && done) overlap = 1'b1;
      if (interfere && i < 9) begin
        start = 1'b1; a = 8'd1; b = 8'd1;
      end else begin
        start = 1'b0; a = 8'($urandom); b = 8'($urandom);
      end
    end
    prod_hold = product;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (product !== 16'h0000) begin failures++; $display("FAIL reset_product got=%h exp=0000", product); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL idle_after_reset busy=%b done=%b exp=0/0", busy, done); end
  endtask

  // Full single-transaction check of latency, pulse, product and hold.
  task automatic test_mul(input string name, input logic [7:0] ia, input logic [7:0] ib);
    int nb, da, nd; logic [15:0] p, ph; bit ov; logic [15:0] exp_p;
    exp_p = ref_mul(ia, ib);
    run_op(ia, ib, 1'b0, nb, da, nd, p, ov, ph);
    checks++; if (nb !== 8) begin failures++; $display("FAIL %s_busy_cycles got=%0d exp=8", name, nb); end
    checks++; if (da !== 8) begin failures++; $display("FAIL %s_done_latency got=%0d exp=8", name, da); end
    checks++; if (nd !== 1) begin failures++; $display("FAIL %s_done_pulses got=%0d exp=1", name, nd); end
    checks++; if (ov !== 1'b0) begin failures++; $display("FAIL %s_busy_done_overlap got=1 exp=0", name); end
    checks++; if (p !== exp_p) begin failures++; $display("FAIL %s_product a=%0d b=%0d got=%0d exp=%0d", name, ia, ib, p, exp_p); end
    checks++; if (ph !== exp_p) begin failures++; $display("FAIL %s_product_hold got=%0d exp=%0d", name, ph, exp_p); end
  endtask

  task automatic test_basic;
    logic [15:0] exp_const;
    exp_const = 16'h087A;
    checks++; if (ref_mul(8'd35, 8'd62) !== exp_const) begin failures++; $display("FAIL ref_model_35x62 got=%h exp=%h", ref_mul(8'd35, 8'd62), exp_const); end
    test_mul("mul_35x62", 8'd35, 8'd62);
  endtask

  task automatic test_values;
    test_mul("mul_19x14", 8'd19, 8'd14);
    test_mul("mul_255x255", 8'd255, 8'd255);
    for (int i = 0; i < 6; i++) test_mul("mul_rand", 8'($urandom), 8'($urandom));
  endtask

  task automatic test_zero;
    test_mul("mul_0x200", 8'd0, 8'd200);
    test_mul("mul_200x0", 8'd200, 8'd0);
  endtask

  task automatic test_ignore_start;
    int nb, da, nd; logic [15:0] p, ph; bit ov;
    run_op(8'd123, 8'd45, 1'b1, nb, da, nd, p, ov, ph);
    checks++; if (nb !== 8) begin failures++; $display("FAIL ignore_busy_cycles got=%0d exp=8", nb); end
    checks++; if (nd !== 1) begin failures++; $display("FAIL ignore_done_pulses got=%0d exp=1", nd); end
    checks++; if (da !== 8) begin failures++; $display("FAIL ignore_done_latency got=%0d exp=8", da); end
    checks++; if (p !== ref_mul(8'd123, 8'd45)) begin failures++; $display("FAIL ignore_product got=%0d exp=%0d", p, ref_mul(8'd123, 8'd45)); end
    checks++; if (ph !== ref_mul(8'd123, 8'd45)) begin failures++; $display("FAIL ignore_product_hold got=%0d exp=%0d", ph, ref_mul(8'd123, 8'd45)); end
  endtask

  task automatic test_reset_mid_run;
    a = 8'd77; b = 8'd91; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrun_busy_before_reset got=%b exp=1", busy); end
    rst = 1'b1;
    #2;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrun_reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL midrun_reset_done got=%b exp=0", done); end
    checks++; if (product !== 16'h0000) begin failures++; $display("FAIL midrun_reset_product got=%h exp=0000", product); end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL midrun_no_resume busy=%b done=%b exp=0/0", busy, done); end
    end
    test_mul("after_reset", 8'd201, 8'd173);
  endtask

  // Start held high with fresh operands every cycle; model accepts whenever
  // the unit is free (10 cycles per product) and scores busy/done/product.
  task automatic test_back_to_back;
    int acc_edge[$];
    logic [15:0] acc_prod[$];
    int free_at;
    int ndone_seen;
    bit exp_busy, exp_done;
    logic [15:0] exp_p;
    free_at = 0; ndone_seen = 0; exp_p = '0;
    start = 1'b1; a = 8'($urandom); b = 8'($urandom);
    for (int t = 0; t < 59; t++) begin
      if (start && t >= free_at) begin
        acc_edge.push_back(t);
        acc_prod.push_back(ref_mul(a, b));
        free_at = t + 10;
      end
      @(posedge clk); #1;
      exp_busy = 1'b0; exp_done = 1'b0;
      for (int k = 0; k < acc_edge.size(); k++) begin
        if (t >= acc_edge[k] && t <= acc_edge[k] + 7) exp_busy = 1'b1;
        if (t == acc_edge[k] + 8) begin exp_done = 1'b1; exp_p = acc_prod[k]; end
      end
      checks++; if (busy !== exp_busy) begin failures++; $display("FAIL b2b_busy t=%0d got=%b exp=%b", t, busy, exp_busy); end
      checks++; if (done !== exp_done) begin failures++; $display("FAIL b2b_done t=%0d got=%b exp=%b", t, done, exp_done); end
      if (exp_done) begin
        ndone_seen++;
        checks++; if (product !== exp_p) begin failures++; $display("FAIL b2b_product t=%0d got=%0d exp=%0d", t, product, exp_p); end
      end
      a = 8'($urandom); b = 8'($urandom);
    end
    checks++; if (ndone_seen !== 6) begin failures++; $display("FAIL b2b_product_count got=%0d exp=6", ndone_seen); end
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    test_reset();
    test_basic();
    test_values();
    test_zero();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
